// File: rtl/reg_file_reader.sv
// Burst reader for a 1-cycle-latency register file. It streams len words from base_addr through
// a 2-entry output buffer with a valid/ready handshake. Optional READ_PARITY_EN adds out_parity.
module reg_file_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef READ_PARITY_EN
  output logic              out_parity,
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W:0]   rd_left;
  logic [ADDR_W:0]   xfer_left;
  logic [1:0]        occ;
  logic              in_flight;
  logic [DATA_W-1:0] slot1;

  logic              push, pop;
  logic [2:0]        used_c;
  logic [1:0]        occ_next;
  logic              head_ld, slot1_ld;
  logic [DATA_W-1:0] head_nxt;

  assign push = in_flight;
  assign pop  = out_valid & out_ready;
  assign busy = (state != IDLE);

  // Credit for the pop at this edge, so a 2-entry buffer sustains one word per cycle.
  assign used_c = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};
  assign rd_en  = (state == FETCH) && (used_c < 3'd2);

  always_comb begin
    occ_next = occ + {1'b0, push} - {1'b0, pop};
    head_ld  = 1'b0;
    head_nxt = out_data;
    if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
      head_ld  = 1'b1;
      head_nxt = rd_data;
    end else if (pop && occ == 2'd2) begin
      head_ld  = 1'b1;
      head_nxt = slot1;
    end
    slot1_ld = push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop));
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      rd_addr   <= '0;
      rd_left   <= '0;
      xfer_left <= '0;
      occ       <= '0;
      in_flight <= 1'b0;
      slot1     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef READ_PARITY_EN
      out_parity <= 1'b0;
`endif
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= rd_en;
      occ       <= occ_next;
      out_valid <= (occ_next != 2'd0);
      if (head_ld) begin
        out_data <= head_nxt;
`ifdef READ_PARITY_EN
        out_parity <= ^head_nxt;
`endif
      end
      if (slot1_ld) slot1 <= rd_data;

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= FETCH;
              rd_addr   <= base_addr;
              rd_left   <= len;
              xfer_left <= len;
            end
          end
        end
        FETCH: begin
          if (rd_en) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            rd_left <= rd_left - (ADDR_W+1)'(1);
            if (rd_left == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        default: ;
      endcase

      // The final transfer can only happen in DRAIN, after the last read has issued.
      if (state != IDLE && pop) begin
        xfer_left <= xfer_left - (ADDR_W+1)'(1);
        if (xfer_left == (ADDR_W+1)'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Randomized bench for reg_file_reader with a queue-based reference model and directed literal cases.
module tb_reg_file_reader;

  logic       Clk = 1'b0;
  logic       R;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef READ_PARITY_EN
  logic       out_parity;
`endif
  logic       busy;
  logic       done;

  reg_file_reader #(.DATA_W(8), .ADDR_W(4)) dut (
    .Clk(Clk), .R(R), .start(start), .base_addr(base_addr), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef READ_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [16];
  int         rdy_mode = 0;
  bit         tp_mode = 1'b0;

  // Register file: data valid one cycle after the strobe, junk otherwise.
  always @(posedge Clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state and logs (written only by the compare process).
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [3:0] addr_q[$];
  bit         par_q[$];
  int         cyc = 0, s_cyc = 0, done_cyc = 0, done_cnt = 0;

  initial begin
    bit         m_active, m_done_next, first_pending, prev_stall, act0;
    logic [3:0] m_addr;
    logic [7:0] prev_data;
    int         m_reads_left, issued, xfered;
    m_active = 0; m_done_next = 0; first_pending = 0; prev_stall = 0;
    m_addr = 0; prev_data = 0; m_reads_left = 0; issued = 0; xfered = 0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!R) begin
        check({rd_en, busy, done, out_valid, rd_addr, out_data} == 16'h0, "reset_outs",
              32'({rd_en, busy, done, out_valid, rd_addr, out_data}), 32'h0);
        exp_q.delete();
        m_active = 0; m_done_next = 0; first_pending = 0; prev_stall = 0;
        issued = 0; xfered = 0;
      end else begin
        act0 = m_active;
        check(done == m_done_next, "done", 32'(done), 32'(m_done_next));
        check(busy == m_active, "busy", 32'(busy), 32'(m_active));
        if (done) begin done_cnt++; done_cyc = cyc; end
        m_done_next = 0;
        if (prev_stall)
          check(out_valid && out_data == prev_data, "stall_hold", 32'({out_valid, out_data}), 32'({1'b1, prev_data}));
`ifdef READ_PARITY_EN
        check(out_parity == ^out_data, "parity", 32'(out_parity), 32'(^out_data));
`endif
        if (!m_active) check(!out_valid, "idle_valid", 32'(out_valid), 32'h0);
        if (first_pending && out_valid) begin
          check(cyc - s_cyc == 3, "first_latency", cyc - s_cyc, 3);
          first_pending = 0;
        end else if (tp_mode && m_active && !first_pending && exp_q.size() != 0) begin
          check(out_valid, "throughput", 32'(out_valid), 32'h1);
        end
        if (rd_en) begin
          check(m_active && m_reads_left > 0, "rd_en_legal", 32'(m_reads_left), 32'h1);
          check(rd_addr == m_addr, "rd_addr", 32'(rd_addr), 32'(m_addr));
          addr_q.push_back(rd_addr);
          m_addr++;
          m_reads_left--;
          issued++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check(1'b0, "extra_word", 32'(out_data), 32'h0);
          else begin
            check(out_data == exp_q[0], "word", 32'(out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          got_q.push_back(out_data);
          got_cyc.push_back(cyc);
`ifdef READ_PARITY_EN
          par_q.push_back(out_parity);
`endif
          xfered++;
          if (m_active && exp_q.size() == 0 && m_reads_left == 0) begin
            m_active = 0;
            m_done_next = 1;
          end
        end
        if (rd_en) check(issued - xfered <= 2, "buf_limit", issued - xfered, 2);
        if (start && !act0) begin
          s_cyc = cyc;
          if (len == 5'd0) m_done_next = 1;
          else begin
            m_active = 1;
            m_addr = base_addr;
            m_reads_left = int'(len);
            issued = 0; xfered = 0;
            first_pending = 1;
            for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[4'(int'(base_addr) + i)]);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  // out_ready patterns: 0 = always, 1 = random, 2 = 1,0,0 repeating.
  initial begin
    int tg;
    tg = 0;
    forever begin
      @(posedge Clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin out_ready = (tg == 0); tg = (tg + 1) % 3; end
      endcase
    end
  end

  task automatic do_start(input logic [3:0] b, input logic [4:0] l);
    @(posedge Clk);
    #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      #1;
      if (done_cnt > d0) break;
    end
    check(done_cnt > d0, name, done_cnt, d0 + 1);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
  endtask

  initial begin
    int g0, a0, d0;
    logic [3:0] b;
    logic [4:0] l;
    R = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    fill_ramp();
    repeat (3) @(posedge Clk);
    #1 R = 1'b1;

    // base 2, len 3, always ready
    rdy_mode = 0; tp_mode = 1;
    g0 = got_q.size(); d0 = done_cnt;
    do_start(4'd2, 5'd3);
    wait_done(d0, "done_b2l3");
    check(got_q.size() - g0 == 3, "b2l3_count", got_q.size() - g0, 3);
    if (got_q.size() - g0 == 3) begin
      check(got_q[g0] == 8'h12, "b2l3_w0", 32'(got_q[g0]), 32'h12);
      check(got_q[g0+1] == 8'h13, "b2l3_w1", 32'(got_q[g0+1]), 32'h13);
      check(got_q[g0+2] == 8'h14, "b2l3_w2", 32'(got_q[g0+2]), 32'h14);
      check(got_cyc[g0] - s_cyc == 3, "b2l3_lat", got_cyc[g0] - s_cyc, 3);
      check(got_cyc[g0+2] - got_cyc[g0] == 2, "b2l3_b2b", got_cyc[g0+2] - got_cyc[g0], 2);
      check(done_cyc - got_cyc[g0+2] == 1, "b2l3_done_at", done_cyc - got_cyc[g0+2], 1);
    end

    // address wrap: base E, len 4
    g0 = got_q.size(); a0 = addr_q.size(); d0 = done_cnt;
    do_start(4'hE, 5'd4);
    wait_done(d0, "done_wrap");
    check(addr_q.size() - a0 == 4, "wrap_nreads", addr_q.size() - a0, 4);
    if (addr_q.size() - a0 == 4) begin
      check(addr_q[a0] == 4'hE && addr_q[a0+1] == 4'hF && addr_q[a0+2] == 4'h0 && addr_q[a0+3] == 4'h1,
            "wrap_addrs", 32'({addr_q[a0], addr_q[a0+1], addr_q[a0+2], addr_q[a0+3]}), 32'hEF01);
    end
    if (got_q.size() - g0 == 4)
      check({got_q[g0], got_q[g0+1], got_q[g0+2], got_q[g0+3]} == 32'h1E1F1011, "wrap_words",
            {got_q[g0], got_q[g0+1], got_q[g0+2], got_q[g0+3]}, 32'h1E1F1011);
    else check(1'b0, "wrap_count", got_q.size() - g0, 4);

    // len 5 with 1,0,0 ready pattern
    rdy_mode = 2; tp_mode = 0;
    g0 = got_q.size(); d0 = done_cnt;
    do_start(4'd0, 5'd5);
    wait_done(d0, "done_toggle");
    check(got_q.size() - g0 == 5, "toggle_count", got_q.size() - g0, 5);
    if (got_q.size() - g0 == 5)
      for (int i = 0; i < 5; i++)
        check(got_q[g0+i] == 8'(8'h10 + i), "toggle_word", 32'(got_q[g0+i]), 32'(8'h10 + i));

    // len 0: done only, no reads
    rdy_mode = 0; tp_mode = 1;
    a0 = addr_q.size(); d0 = done_cnt;
    do_start(4'd5, 5'd0);
    wait_done(d0, "done_len0");
    check(done_cyc - s_cyc == 1, "len0_done_at", done_cyc - s_cyc, 1);
    check(addr_q.size() == a0, "len0_no_rd", addr_q.size() - a0, 0);

    // reset mid-burst after 2 of 6 words, then start immediately on release
    g0 = got_q.size();
    do_start(4'd0, 5'd6);
    for (int i = 0; i < 50; i++) begin
      @(posedge Clk);
      if (got_q.size() - g0 >= 2) break;
    end
    #2 R = 1'b0;
    #1;
    check({rd_en, busy, done, out_valid, rd_addr, out_data} == 16'h0, "async_reset",
          32'({rd_en, busy, done, out_valid, rd_addr, out_data}), 32'h0);
`ifdef READ_PARITY_EN
    check(out_parity == 1'b0, "reset_parity", 32'(out_parity), 32'h0);
`endif
    @(posedge Clk);
    #1;
    g0 = got_q.size(); d0 = done_cnt;
    R = 1'b1; start = 1'b1; base_addr = 4'd0; len = 5'd1;
    @(posedge Clk);
    #1 start = 1'b0;
    wait_done(d0, "done_after_reset");
    check(done_cnt - d0 == 1, "after_reset_ndone", done_cnt - d0, 1);
    check(got_q.size() - g0 == 1, "after_reset_count", got_q.size() - g0, 1);
    if (got_q.size() - g0 == 1) check(got_q[g0] == 8'h10, "after_reset_word", 32'(got_q[g0]), 32'h10);

`ifdef READ_PARITY_EN
    mem[0] = 8'h07; mem[1] = 8'h03;
    g0 = par_q.size(); d0 = done_cnt;
    do_start(4'd0, 5'd2);
    wait_done(d0, "done_parity");
    if (par_q.size() - g0 == 2) begin
      check(par_q[g0] == 1'b1, "parity_07", 32'(par_q[g0]), 32'h1);
      check(par_q[g0+1] == 1'b0, "parity_03", 32'(par_q[g0+1]), 32'h0);
    end else check(1'b0, "parity_count", par_q.size() - g0, 2);
`endif

    // randomized bursts
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      rdy_mode = $urandom_range(0, 2);
      tp_mode = (rdy_mode == 0);
      b = 4'($urandom_range(0, 15));
      l = (k % 7 == 3) ? 5'd0 : 5'($urandom_range(1, 16));
      d0 = done_cnt;
      repeat (2) @(posedge Clk);
      do_start(b, l);
      if (l >= 5'd4 && $urandom_range(0, 1) == 1) begin
        start = 1'b1; base_addr = 4'($urandom); len = 5'($urandom_range(0, 16));
        @(posedge Clk);
        #1 start = 1'b0;
      end
      wait_done(d0, "done_random");
    end

    repeat (3) @(posedge Clk);
    check(exp_q.size() == 0, "leftover_words", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
